ysyx_25030085_core_seq: RTL and testbench
=========================================

# ysyx_25030085_core_seq

Multi-cycle instruction sequencer for the next-generation NPC core. It replaces the free-running single-cycle top with a handshaked fetch/execute/memory/writeback FSM. It owns the PC and instruction registers, drives valid/ready instruction and data buses, and aligns and extends load/store data. Decode, regfile and ALU remain combinational neighbours: they read `pc` and `inst` and feed back `next_pc`, `alu_result`, `rs2_data` and the decoded control bits.

## Interface
- `XLEN`, 32: datapath and address width; only 32 is supported in this generation.
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high; one clock only.
- `ifu_req_valid` / `ifu_req_ready`  out/in  1  fetch request handshake.
- `ifu_addr`  out  XLEN  fetch address, equal to `pc`.
- `ifu_rsp_valid`  in  1  fetch data valid.
- `ifu_rdata`  in  32  instruction word.
- `lsu_req_valid` / `lsu_req_ready`  out/in  1  data request handshake.
- `lsu_addr`  out  XLEN  word-aligned address: `alu_result & ~3`.
- `lsu_wen`  out  1  1 = store.
- `lsu_wstrb`  out  4  byte enables.
- `lsu_wdata`  out  32  lane-shifted store data.
- `lsu_rsp_valid`  in  1  load data or store ack.
- `lsu_rdata`  in  32  word read.
- `mem_read`, `mem_write`, `reg_write`  in  1 each  decoded control.
- `mem_op`  in  3  funct3-style size code.
- `next_pc`, `alu_result`, `rs2_data`  in  XLEN  datapath results.
- `pc`  out  XLEN  current PC.
- `inst`  out  32  latched instruction.
- `rf_we`  out  1  regfile write pulse.
- `load_data`  out  XLEN  extended load result; valid while `rf_we` is high.
- `commit`  out  1  one-cycle retire pulse.
- `err`  out  1  sticky misalignment flag.

## Operation
- States: FETCH, FWAIT, EXEC, MREQ, MWAIT, WB, HALT.
- FETCH: assert `ifu_req_valid`. On `ifu_req_ready`, go to FWAIT.
- FWAIT: when `ifu_rsp_valid`, load `inst` from `ifu_rdata`, then go to EXEC.
- EXEC:
  - If neither `mem_read` nor `mem_write`: `rf_we = reg_write`, `pc <= next_pc`, pulse `commit`, go to FETCH.
  - Otherwise latch the address, store data and `mem_op`, then go to MREQ. If the access is misaligned, go to HALT instead.
- Misaligned: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
- MREQ: assert `lsu_req_valid`. On `lsu_req_ready`, go to MWAIT.
- MWAIT: on `lsu_rsp_valid`, latch `lsu_rdata`, then go to WB.
- WB: `rf_we = reg_write & mem_read`, `pc <= next_pc`, pulse `commit`, go to FETCH.
- HALT: `err` = 1; no requests, no commits. Only `rst` exits HALT.
- Load extract: shift the word right by `8*addr[1:0]`.
  - `mem_op` 000 = LB, sign-extend from bit 7.
  - 001 = LH, sign-extend from bit 15.
  - 010 = LW.
  - 100 = LBU, zero-extend.
  - 101 = LHU, zero-extend.
  - Other codes behave as LW.
- Store, selected by `mem_op[1:0]`:
  - SB: `wstrb = 0001 << a`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wstrb = 0011 << a`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wstrb = 1111`, `wdata = rs2`.
  - `lsu_wstrb` = 0 whenever `lsu_wen` = 0.

## Timing
- Reset values: `pc = RESET_PC`, `inst = 32'h0000_0013` (nop), state FETCH, `err = 0`; all valid, `rf_we` and `commit` outputs are 0.
- First `ifu_req_valid` appears in the cycle after `rst` is deasserted.
- Valid is held, and address/data stay stable, until ready is seen. Valid never drops without a handshake.
- Responses are sampled only in FWAIT/MWAIT, earliest the cycle after acceptance. A response arriving in any other state is ignored.
- Zero-wait latency: non-memory instruction 3 cycles; load or store 6 cycles, measured FETCH to `commit`.
- `rf_we` and `commit` are single-cycle pulses, coincident with the PC update.
- `rst` mid-operation in any state, including HALT, aborts the instruction. No `commit` or `rf_we` is generated. Any late bus response is discarded.

## Structure
- Package `ysyx_25030085_core_pkg` holds:
  - the state enum;
  - `mem_op` encodings (MEM_LB … MEM_LHU, MEM_SB/SH/SW);
  - the default `RESET_PC`;
  - the nop constant.
- Sub-module `ysyx_25030085_lsu_align` is combinational. It covers the misalign check, strobe/wdata generation and load extract/extend.

## Test plan
- Reset then release, with `ifu_req_ready` = 1 → `ifu_addr` = 0x8000_0000 one cycle after release; `pc` unchanged until `commit`.
- ADDI fetch with `ifu_req_ready` low for 2 cycles → valid and address held; `commit` lands 5 cycles after release; `pc` = `next_pc` = 0x8000_0004.
- LB at `alu_result` 0x8000_1003 with `lsu_rdata` 0x8000_0000 → `lsu_addr` 0x8000_1000, `lsu_wen` 0, `load_data` 0xFFFF_FF80 with `rf_we` high; LBU → 0x0000_0080.
- SH at offset 2 with `rs2` 0x0000_1234 → `lsu_wstrb` 1100, `lsu_wdata` 0x1234_1234; no `rf_we`; `commit` after ack.
- LW at 0x…02 → no LSU request; `err` = 1 and stays in HALT; `rst` clears it and fetching resumes at `RESET_PC`.
- `rst` during MWAIT, then `lsu_rsp_valid` next cycle → response ignored; no `commit`; clean fetch from `RESET_PC`.

Source files
------------

// File: rtl/ysyx_25030085_core_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_core_pkg
// Shared types and constants for the multi-cycle instruction sequencer:
//   - state_e       : sequencer FSM states
//   - MEM_*         : funct3-style load/store size codes
//   - DEFAULT_RESET_PC, NOP_INST
//   - is_misaligned : alignment rule shared by the sequencer and LSU aligner
// ----------------------------------------------------------------------------
package ysyx_25030085_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_FWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MREQ  = 3'd3,
    S_MWAIT = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  // Load codes
  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  // Store codes (only [1:0] is significant for stores)
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

  // Size comes from op[1:0]: 00 byte (never misaligned), 01 halfword,
  // anything else is treated as a word (loads with unknown codes act as LW).
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    logic mis;
    case (op[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25030085_core_seq_if.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_core_seq_if
// Instruction (ifu_*) and data (lsu_*) valid/ready buses of the sequencer.
//   master : the core side (drives requests, receives responses)
//   slave  : the memory side
// ----------------------------------------------------------------------------
interface ysyx_25030085_core_seq_if #(
  parameter int XLEN = 32
);
  // instruction fetch bus
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rdata;
  // data bus
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [XLEN-1:0] lsu_addr;
  logic            lsu_wen;
  logic [3:0]      lsu_wstrb;
  logic [31:0]     lsu_wdata;
  logic            lsu_rsp_valid;
  logic [31:0]     lsu_rdata;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wstrb, lsu_wdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wstrb, lsu_wdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata
  );
endinterface

// File: rtl/ysyx_25030085_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_lsu_align  (combinational)
// Byte-lane handling for the data bus.
//   i_addr_lo     : byte offset within the word
//   i_mem_op      : funct3-style size code
//   i_wen         : 1 = store; strobes are forced to 0 otherwise
//   i_rs2         : store source data
//   i_rdata       : word read from memory
//   o_misaligned  : access crosses its natural alignment
//   o_wstrb       : byte enables
//   o_wdata       : store data replicated onto every lane
//   o_load_data   : shifted and sign/zero-extended load result
// ----------------------------------------------------------------------------
module ysyx_25030085_lsu_align
  import ysyx_25030085_core_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_mem_op,
  input  logic        i_wen,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [3:0]  w_strb;
  logic [31:0] w_shifted;

  always_comb begin
    o_misaligned = is_misaligned(i_mem_op, i_addr_lo);

    // Replicating the data means the memory only needs the strobes to
    // pick the right lane; no data shifter on the store path.
    w_strb  = 4'b1111;
    o_wdata = i_rs2;
    case (i_mem_op[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_rs2[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        o_wdata = i_rs2;
      end
    endcase
    o_wstrb = i_wen ? w_strb : 4'b0000;

    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    case (i_mem_op)
      MEM_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_LBU: o_load_data = {24'h0, w_shifted[7:0]};
      MEM_LHU: o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_core_seq.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_core_seq
// Multi-cycle fetch/execute/memory/writeback sequencer. Owns PC and the
// instruction register; decode, regfile and ALU are combinational neighbours.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : ifu_* / lsu_* valid/ready buses (master side)
//   mem_read, mem_write, reg_write, mem_op : decoded control
//   next_pc, alu_result, rs2_data          : datapath results
//   pc, inst      : current PC, latched instruction
//   rf_we         : regfile write pulse, load_data valid with it
//   commit        : one-cycle retire pulse (same edge as the PC update)
//   err           : sticky misalignment flag; core sits in HALT until rst
// Zero-wait latency: 3 cycles (ALU op) / 6 cycles (load/store) to commit.
// ----------------------------------------------------------------------------
module ysyx_25030085_core_seq
  import ysyx_25030085_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25030085_core_seq_if.master   bus,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic                       reg_write,
  input  logic [2:0]                 mem_op,
  input  logic [XLEN-1:0]            next_pc,
  input  logic [XLEN-1:0]            alu_result,
  input  logic [XLEN-1:0]            rs2_data,
  output logic [XLEN-1:0]            pc,
  output logic [31:0]                inst,
  output logic                       rf_we,
  output logic [XLEN-1:0]            load_data,
  output logic                       commit,
  output logic                       err
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_ifu_req_valid;
  logic            r_lsu_req_valid;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_mem_op;
  logic            r_wen;
  logic [31:0]     r_rdata;
  logic            r_rf_we;
  logic            r_commit;
  logic [XLEN-1:0] r_load_data;
  logic            r_err;

  logic            w_in_exec;
  logic [1:0]      w_align_addr;
  logic [2:0]      w_align_op;
  logic            w_misaligned;
  logic [3:0]      w_wstrb;
  logic [31:0]     w_wdata;
  logic [31:0]     w_load_data;

  // One aligner serves both phases: in EXEC it checks the live address for
  // misalignment; afterwards it works from the latched access so that the
  // request stays stable while waiting for ready.
  assign w_in_exec    = (r_state == S_EXEC);
  assign w_align_addr = w_in_exec ? alu_result[1:0] : r_addr[1:0];
  assign w_align_op   = w_in_exec ? mem_op : r_mem_op;

  ysyx_25030085_lsu_align u_align (
    .i_addr_lo    (w_align_addr),
    .i_mem_op     (w_align_op),
    .i_wen        (r_wen),
    .i_rs2        (r_wdata),
    .i_rdata      (r_rdata),
    .o_misaligned (w_misaligned),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_inst          <= NOP_INST;
      r_ifu_req_valid <= 1'b0;
      r_lsu_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_mem_op        <= 3'b000;
      r_wen           <= 1'b0;
      r_rdata         <= 32'h0;
      r_rf_we         <= 1'b0;
      r_commit        <= 1'b0;
      r_load_data     <= '0;
      r_err           <= 1'b0;
    end else begin
      r_rf_we  <= 1'b0;
      r_commit <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // Valid comes up one cycle after entering FETCH from reset, and
          // only drops once the request is accepted.
          if (r_ifu_req_valid && bus.ifu_req_ready) begin
            r_ifu_req_valid <= 1'b0;
            r_state         <= S_FWAIT;
          end else begin
            r_ifu_req_valid <= 1'b1;
          end
        end
        S_FWAIT: begin
          if (bus.ifu_rsp_valid) begin
            r_inst  <= bus.ifu_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!mem_read && !mem_write) begin
            r_rf_we         <= reg_write;
            r_pc            <= next_pc;
            r_commit        <= 1'b1;
            r_ifu_req_valid <= 1'b1;
            r_state         <= S_FETCH;
          end else begin
            r_addr   <= alu_result;
            r_wdata  <= rs2_data;
            r_mem_op <= mem_op;
            r_wen    <= mem_write;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_lsu_req_valid <= 1'b1;
              r_state         <= S_MREQ;
            end
          end
        end
        S_MREQ: begin
          if (r_lsu_req_valid && bus.lsu_req_ready) begin
            r_lsu_req_valid <= 1'b0;
            r_state         <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (bus.lsu_rsp_valid) begin
            r_rdata <= bus.lsu_rdata;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_rf_we         <= reg_write & mem_read;
          r_load_data     <= w_load_data;
          r_pc            <= next_pc;
          r_commit        <= 1'b1;
          r_ifu_req_valid <= 1'b1;
          r_state         <= S_FETCH;
        end
        S_HALT: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.ifu_req_valid = r_ifu_req_valid;
  assign bus.ifu_addr      = r_pc;
  assign bus.lsu_req_valid = r_lsu_req_valid;
  assign bus.lsu_addr      = {r_addr[XLEN-1:2], 2'b00};
  assign bus.lsu_wen       = r_wen;
  assign bus.lsu_wstrb     = w_wstrb;
  assign bus.lsu_wdata     = w_wdata;

  assign pc        = r_pc;
  assign inst      = r_inst;
  assign rf_we     = r_rf_we;
  assign load_data = r_load_data;
  assign commit    = r_commit;
  assign err       = r_err;

endmodule

// File: tb/tb_ysyx_25030085_core_seq.sv
module tb_ysyx_25030085_core_seq;
  import ysyx_25030085_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] next_pc = 32'h0, alu_result = 32'h0, rs2_data = 32'h0;
  logic [31:0] pc, inst, load_data;
  logic        rf_we, commit, err;

  int errors = 0;
  int checks = 0;

  ysyx_25030085_core_seq_if bus ();

  ysyx_25030085_core_seq dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_op     (mem_op),
    .next_pc    (next_pc),
    .alu_result (alu_result),
    .rs2_data   (rs2_data),
    .pc         (pc),
    .inst       (inst),
    .rf_we      (rf_we),
    .load_data  (load_data),
    .commit     (commit),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rdata     = 32'h0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rdata     = 32'h0;
  endtask

  // Leaves the bench just after the first edge with rst low (FETCH, valid up).
  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_dec(input logic mr, input logic mw, input logic rw, input logic [2:0] op,
                         input logic [31:0] npc, input logic [31:0] alu, input logic [31:0] rs2);
    mem_read = mr; mem_write = mw; reg_write = rw; mem_op = op;
    next_pc = npc; alu_result = alu; rs2_data = rs2;
  endtask

  // From FETCH with valid high: accept request, return the word; ends in EXEC.
  task automatic fetch_inst(input logic [31:0] word);
    bus.ifu_req_ready = 1'b1;
    tick();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata     = word;
    tick();
    bus.ifu_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    set_dec(1'b0, 1'b0, 1'b1, 3'b000, 32'h8000_0004, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0000_0013); end
    checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_ifu_valid: got %b want 0", bus.ifu_req_valid); end
    checks++; if (bus.lsu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_lsu_valid: got %b want 0", bus.lsu_req_valid); end
    checks++; if ({commit, rf_we, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {commit, rf_we, err}); end
    rst = 1'b0;
    bus.ifu_req_ready = 1'b1;
    tick();
    checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b want 1", bus.ifu_req_valid); end
    checks++; if (bus.ifu_addr !== 32'h8000_0000) begin errors++; $display("FAIL release_addr: got %h want %h", bus.ifu_addr, 32'h8000_0000); end
    tick();
    bus.ifu_req_ready = 1'b0;
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL fwait_pc: got %h want %h", pc, 32'h8000_0000); end
    checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL fwait_valid_drop: got %b want 0", bus.ifu_req_valid); end
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata = 32'h0010_0093;
    tick();
    bus.ifu_rsp_valid = 1'b0;
    checks++; if (inst !== 32'h0010_0093) begin errors++; $display("FAIL exec_inst: got %h want %h", inst, 32'h0010_0093); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL exec_no_commit: got %b want 0", commit); end
    tick();
    checks++; if ({commit, rf_we} !== 2'b11) begin errors++; $display("FAIL first_commit: got %b want 11", {commit, rf_we}); end
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL first_commit_pc: got %h want %h", pc, 32'h8000_0004); end
    $display("txn reset+addi: pc=%h inst=%h", pc, inst);
  endtask

  task automatic test_addi_stall();
    do_reset();
    set_dec(1'b0, 1'b0, 1'b1, 3'b000, 32'h8000_0004, 32'h0000_0001, 32'h0);
    // Edge 0 after release: valid up, ready low for this and the next cycle.
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.ifu_req_valid !== 1'b1 || bus.ifu_addr !== 32'h8000_0000) begin
        errors++; $display("FAIL stall_hold c%0d: got v=%b a=%h want v=1 a=%h", c, bus.ifu_req_valid, bus.ifu_addr, 32'h8000_0000);
      end
      checks++; if (commit !== 1'b0) begin errors++; $display("FAIL stall_early_commit c%0d: got %b want 0", c, commit); end
      if (c == 2) bus.ifu_req_ready = 1'b1;
      tick();
    end
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata = 32'h0010_0093;
    tick();
    bus.ifu_rsp_valid = 1'b0;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL stall_commit_c4: got %b want 0", commit); end
    tick();
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL stall_commit_c5: got %b want 1", commit); end
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL stall_pc: got %h want %h", pc, 32'h8000_0004); end
    tick();
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL commit_single_pulse: got %b want 0", commit); end
    $display("txn addi stalled: pc=%h", pc);
  endtask

  // Entered in FETCH with valid high.
  task automatic test_load(input logic [2:0] op, input logic [31:0] npc, input logic [31:0] exp);
    set_dec(1'b1, 1'b0, 1'b1, op, npc, 32'h8000_1003, 32'hFFFF_FFFF);
    fetch_inst(32'h0030_8083);
    tick();
    checks++; if (bus.lsu_req_valid !== 1'b1) begin errors++; $display("FAIL ld_req_valid op%b: got %b want 1", op, bus.lsu_req_valid); end
    checks++; if (bus.lsu_addr !== 32'h8000_1000) begin errors++; $display("FAIL ld_addr op%b: got %h want %h", op, bus.lsu_addr, 32'h8000_1000); end
    checks++; if (bus.lsu_wen !== 1'b0 || bus.lsu_wstrb !== 4'b0000) begin
      errors++; $display("FAIL ld_wen op%b: got wen=%b strb=%b want 0/0000", op, bus.lsu_wen, bus.lsu_wstrb);
    end
    bus.lsu_req_ready = 1'b1;
    tick();
    bus.lsu_req_ready = 1'b0;
    checks++; if (bus.lsu_req_valid !== 1'b0) begin errors++; $display("FAIL ld_valid_drop op%b: got %b want 0", op, bus.lsu_req_valid); end
    bus.lsu_rsp_valid = 1'b1;
    bus.lsu_rdata = 32'h8000_0000;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL ld_wb_commit op%b: got %b want 0", op, commit); end
    tick();
    checks++; if ({commit, rf_we} !== 2'b11) begin errors++; $display("FAIL ld_commit op%b: got %b want 11", op, {commit, rf_we}); end
    checks++; if (load_data !== exp) begin errors++; $display("FAIL ld_data op%b: got %h want %h", op, load_data, exp); end
    checks++; if (pc !== npc) begin errors++; $display("FAIL ld_pc op%b: got %h want %h", op, pc, npc); end
    $display("txn load op=%b addr=%h data=%h", op, 32'h8000_1003, load_data);
  endtask

  task automatic test_loads();
    do_reset();
    test_load(MEM_LB, 32'h8000_0004, 32'hFFFF_FF80);
    checks++; if (bus.ifu_addr !== 32'h8000_0004) begin errors++; $display("FAIL b2b_fetch_addr: got %h want %h", bus.ifu_addr, 32'h8000_0004); end
    test_load(MEM_LBU, 32'h8000_0008, 32'h0000_0080);
  endtask

  task automatic test_store_sh();
    set_dec(1'b0, 1'b1, 1'b0, MEM_SH, 32'h8000_000C, 32'h8000_1002, 32'h0000_1234);
    fetch_inst(32'h0020_9123);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.lsu_req_valid !== 1'b1 || bus.lsu_addr !== 32'h8000_1000 || bus.lsu_wen !== 1'b1) begin
        errors++; $display("FAIL sh_req c%0d: got v=%b a=%h wen=%b want 1/%h/1", c, bus.lsu_req_valid, bus.lsu_addr, bus.lsu_wen, 32'h8000_1000);
      end
      checks++; if (bus.lsu_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb c%0d: got %b want 1100", c, bus.lsu_wstrb); end
      checks++; if (bus.lsu_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata c%0d: got %h want %h", c, bus.lsu_wdata, 32'h1234_1234); end
      // Ready held low on the first request cycle to check the request is held.
      alu_result = 32'h0000_0000;
      rs2_data   = 32'hAAAA_AAAA;
      if (c == 1) bus.lsu_req_ready = 1'b1;
    end
    tick();
    bus.lsu_req_ready = 1'b0;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL sh_commit_before_ack: got %b want 0", commit); end
    bus.lsu_rsp_valid = 1'b1;
    bus.lsu_rdata = 32'hDEAD_BEEF;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    tick();
    checks++; if ({commit, rf_we} !== 2'b10) begin errors++; $display("FAIL sh_commit: got %b want 10", {commit, rf_we}); end
    checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL sh_pc: got %h want %h", pc, 32'h8000_000C); end
    $display("txn store sh addr=%h strb=1100 pc=%h", 32'h8000_1002, pc);
  endtask

  task automatic test_misalign_halt();
    do_reset();
    set_dec(1'b1, 1'b0, 1'b1, MEM_LW, 32'h8000_0004, 32'h8000_1002, 32'h0);
    fetch_inst(32'h0020_A083);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL halt_err: got %b want 1", err); end
    checks++; if (bus.lsu_req_valid !== 1'b0) begin errors++; $display("FAIL halt_no_lsu: got %b want 0", bus.lsu_req_valid); end
    bus.ifu_req_ready = 1'b1; bus.ifu_rsp_valid = 1'b1;
    bus.lsu_req_ready = 1'b1; bus.lsu_rsp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({err, bus.ifu_req_valid, bus.lsu_req_valid, commit, rf_we} !== 5'b10000) begin
        errors++; $display("FAIL halt_stuck c%0d: got %b want 10000", c, {err, bus.ifu_req_valid, bus.lsu_req_valid, commit, rf_we});
      end
    end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL halt_pc: got %h want %h", pc, 32'h8000_0000); end
    idle_bus();
    rst = 1'b1;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL halt_rst_err: got %b want 0", err); end
    rst = 1'b0;
    tick();
    checks++; if (bus.ifu_req_valid !== 1'b1 || bus.ifu_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL halt_resume: got v=%b a=%h want 1/%h", bus.ifu_req_valid, bus.ifu_addr, 32'h8000_0000);
    end
    $display("txn lw misaligned addr=%h err->halt, rst resumes", 32'h8000_1002);
  endtask

  task automatic test_rst_mwait();
    do_reset();
    set_dec(1'b1, 1'b0, 1'b1, MEM_LW, 32'h8000_0004, 32'h8000_1000, 32'h0);
    fetch_inst(32'h0000_A083);
    tick();
    bus.lsu_req_ready = 1'b1;
    tick();
    bus.lsu_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    bus.lsu_rdata = 32'h1234_5678;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    checks++; if ({commit, rf_we} !== 2'b00) begin errors++; $display("FAIL abort_no_commit: got %b want 00", {commit, rf_we}); end
    checks++; if (bus.ifu_req_valid !== 1'b1 || pc !== 32'h8000_0000) begin
      errors++; $display("FAIL abort_refetch: got v=%b pc=%h want 1/%h", bus.ifu_req_valid, pc, 32'h8000_0000);
    end
    checks++; if (bus.lsu_req_valid !== 1'b0) begin errors++; $display("FAIL abort_lsu_idle: got %b want 0", bus.lsu_req_valid); end
    // Stray fetch response while still in FETCH must not reach inst.
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata = 32'hCAFE_0000;
    tick();
    bus.ifu_rsp_valid = 1'b0;
    checks++; if (inst !== 32'h0000_0013 || commit !== 1'b0) begin
      errors++; $display("FAIL abort_stray_rsp: got inst=%h commit=%b want %h/0", inst, commit, 32'h0000_0013);
    end
    set_dec(1'b0, 1'b0, 1'b1, 3'b000, 32'h8000_0004, 32'h0, 32'h0);
    fetch_inst(32'h0010_0093);
    tick();
    checks++; if (commit !== 1'b1 || pc !== 32'h8000_0004) begin
      errors++; $display("FAIL abort_clean_commit: got c=%b pc=%h want 1/%h", commit, pc, 32'h8000_0004);
    end
    $display("txn rst in mwait: late rsp dropped, refetch pc=%h", pc);
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_addi_stall();
    test_loads();
    test_store_sh();
    test_misalign_halt();
    test_rst_mwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
